// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT/IFFT blocks: Q1.17 twiddles,
// IFFT sequencing states and the 4-bit bit-reversal helper.
package fft_pkg;

    localparam int unsigned FFT_WIDTH = 36;

    function automatic logic [FFT_WIDTH-1:0] conj36(input logic [FFT_WIDTH-1:0] w);
        return {w[FFT_WIDTH-1:FFT_WIDTH/2], 18'(-w[FFT_WIDTH/2-1:0])};
    endfunction

    // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16); magnitude 1.0 is stored as 2^17-1
    localparam logic [FFT_WIDTH-1:0] W16_0 = {18'h1FFFF, 18'h00000};
    localparam logic [FFT_WIDTH-1:0] W16_1 = {18'h1D907, 18'h33C11};
    localparam logic [FFT_WIDTH-1:0] W16_2 = {18'h16A0A, 18'h295F6};
    localparam logic [FFT_WIDTH-1:0] W16_3 = {18'h0C3EF, 18'h226F9};
    localparam logic [FFT_WIDTH-1:0] W16_4 = {18'h00000, 18'h20001};
    localparam logic [FFT_WIDTH-1:0] W16_5 = {18'h33C11, 18'h226F9};
    localparam logic [FFT_WIDTH-1:0] W16_6 = {18'h295F6, 18'h295F6};
    localparam logic [FFT_WIDTH-1:0] W16_7 = {18'h226F9, 18'h33C11};

    localparam logic [FFT_WIDTH-1:0] W16C_0 = conj36(W16_0);
    localparam logic [FFT_WIDTH-1:0] W16C_1 = conj36(W16_1);
    localparam logic [FFT_WIDTH-1:0] W16C_2 = conj36(W16_2);
    localparam logic [FFT_WIDTH-1:0] W16C_3 = conj36(W16_3);
    localparam logic [FFT_WIDTH-1:0] W16C_4 = conj36(W16_4);
    localparam logic [FFT_WIDTH-1:0] W16C_5 = conj36(W16_5);
    localparam logic [FFT_WIDTH-1:0] W16C_6 = conj36(W16_6);
    localparam logic [FFT_WIDTH-1:0] W16C_7 = conj36(W16_7);

    typedef enum logic [2:0] {
        IFFT_IDLE = 3'd0,
        IFFT_S1   = 3'd1,
        IFFT_S2   = 3'd2,
        IFFT_S3   = 3'd3,
        IFFT_S4   = 3'd4
    } ifft_state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    function automatic logic [FFT_WIDTH-1:0] twiddle_conj(input logic [2:0] k);
        logic [FFT_WIDTH-1:0] w;
        case (k)
            3'd0:    w = W16C_0;
            3'd1:    w = W16C_1;
            3'd2:    w = W16C_2;
            3'd3:    w = W16C_3;
            3'd4:    w = W16C_4;
            3'd5:    w = W16C_5;
            3'd6:    w = W16C_6;
            default: w = W16C_7;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ifft_butterfly_scaled.sv
// Combinational scaled radix-2 butterfly: X = (A + W*B)/2, Y = (A - W*B)/2,
// with a guard bit on the sum/difference so halving never overflows.
module ifft_butterfly_scaled #(
    parameter int unsigned WIDTH = 36
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] W,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y
);

    localparam int unsigned H = WIDTH / 2;

    logic signed [H-1:0]   ar, ai, br, bi, wr, wi;
    logic signed [2*H-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [2*H:0]   p_re_full, p_im_full;
    logic signed [H-1:0]   p_re, p_im;
    logic signed [H:0]     s_re, s_im, d_re, d_im;
    logic                  unity;

    assign ar = A[WIDTH-1:H];
    assign ai = A[H-1:0];
    assign br = B[WIDTH-1:H];
    assign bi = B[H-1:0];
    assign wr = W[WIDTH-1:H];
    assign wi = W[H-1:0];

    assign m_rr = (2*H)'(wr) * (2*H)'(br);
    assign m_ii = (2*H)'(wi) * (2*H)'(bi);
    assign m_ri = (2*H)'(wr) * (2*H)'(bi);
    assign m_ir = (2*H)'(wi) * (2*H)'(br);

    assign p_re_full = (2*H+1)'(m_rr) - (2*H+1)'(m_ii);
    assign p_im_full = (2*H+1)'(m_ri) + (2*H+1)'(m_ir);

    // 1.0 is only approximable, so the k=0 twiddle passes B through exactly
    assign unity = (wr == {1'b0, {(H-1){1'b1}}}) && (wi == '0);

    assign p_re = unity ? br : p_re_full[2*H-2:H-1];
    assign p_im = unity ? bi : p_im_full[2*H-2:H-1];

    assign s_re = (H+1)'(ar) + (H+1)'(p_re);
    assign s_im = (H+1)'(ai) + (H+1)'(p_im);
    assign d_re = (H+1)'(ar) - (H+1)'(p_re);
    assign d_im = (H+1)'(ai) - (H+1)'(p_im);

    assign X = {s_re[H:1], s_im[H:1]};
    assign Y = {d_re[H:1], d_im[H:1]};

endmodule

// File: rtl/ifft_16pt.sv
// 16-point radix-2 DIT inverse FFT: one butterfly stage per clock, 1/16 scaling.
// Twiddle table is defined for WIDTH = 36.
module ifft_16pt
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 36
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] F [0:15],
    output logic [WIDTH-1:0] f [0:15],
    output logic             busy,
    output logic             done
);

    ifft_state_t      state;
    logic [WIDTH-1:0] work [0:15];
    logic [WIDTH-1:0] nxt  [0:15];
    logic [WIDTH-1:0] bf_a [0:7];
    logic [WIDTH-1:0] bf_b [0:7];
    logic [WIDTH-1:0] bf_w [0:7];
    logic [WIDTH-1:0] bf_x [0:7];
    logic [WIDTH-1:0] bf_y [0:7];
    logic [3:0]       ia   [0:7];
    logic [3:0]       ib   [0:7];
    logic [2:0]       tk   [0:7];
    int unsigned      stage_lg;

    always_comb begin
        case (state)
            IFFT_S2: stage_lg = 1;
            IFFT_S3: stage_lg = 2;
            IFFT_S4: stage_lg = 3;
            default: stage_lg = 0;
        endcase
    end

    // butterfly b pairs (j, j+span): j = (b/span)*2span + b mod span
    always_comb begin
        for (int unsigned b = 0; b < 8; b++) begin
            ia[b] = 4'(((b >> stage_lg) << (stage_lg + 1)) | (b & ((32'd1 << stage_lg) - 32'd1)));
            ib[b] = 4'(((b >> stage_lg) << (stage_lg + 1)) | (b & ((32'd1 << stage_lg) - 32'd1))
                       | (32'd1 << stage_lg));
            tk[b] = 3'((b & ((32'd1 << stage_lg) - 32'd1)) << (32'd3 - stage_lg));
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < 8; b++) begin
            bf_a[b] = work[ia[b]];
            bf_b[b] = work[ib[b]];
            bf_w[b] = WIDTH'(twiddle_conj(tk[b]));
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_bf
        ifft_butterfly_scaled #(.WIDTH(WIDTH)) u_bf (
            .A (bf_a[g]),
            .B (bf_b[g]),
            .W (bf_w[g]),
            .X (bf_x[g]),
            .Y (bf_y[g])
        );
    end

    always_comb begin
        nxt = work;
        for (int unsigned b = 0; b < 8; b++) begin
            nxt[ia[b]] = bf_x[b];
            nxt[ib[b]] = bf_y[b];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IFFT_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            work  <= '{default: '0};
            f     <= '{default: '0};
        end else begin
            done <= 1'b0;
            case (state)
                IFFT_IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < 16; i++)
                            work[bitrev4(4'(i))] <= F[i];
                        busy  <= 1'b1;
                        state <= IFFT_S1;
                    end
                end
                IFFT_S1: begin
                    work  <= nxt;
                    state <= IFFT_S2;
                end
                IFFT_S2: begin
                    work  <= nxt;
                    state <= IFFT_S3;
                end
                IFFT_S3: begin
                    work  <= nxt;
                    state <= IFFT_S4;
                end
                IFFT_S4: begin
                    f     <= nxt;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IFFT_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IFFT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ifft_16pt.md
Name: ifft_16pt

Overview:
16-point radix-2 decimation-in-time inverse FFT, packed complex fixed point. It is the inverse of the fft_16pt block: it takes spectrum bins F[0:15] and returns time samples f[0:15], scaled by 1/16, so that f = IFFT(FFT(f)).
- Iterative datapath with 8 scaled butterflies, one stage per clock.
- Inputs captured on start; start/busy/done handshake.

Parameters:
WIDTH, 36, packed complex word: re = [WIDTH-1:WIDTH/2], im = [WIDTH/2-1:0]; each half is two's-complement Q1.(WIDTH/2-1).

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request; sampled only in IDLE
F      in  WIDTH x16 (unpacked [0:15])  spectrum bins, natural order
f      out  WIDTH x16 (unpacked [0:15])  time samples, natural order, registered
busy   out  1  high from the edge that accepts start until the edge that writes results
done   out  1  one-cycle pulse: f updated on this edge

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, busy=0, done=0, all f words 0, work registers 0.
- States: IDLE, S1, S2, S3, S4; state register is 3 bits and unused encodings go to IDLE.
- Edge N, IDLE with start=1:
  - work[bitrev4(i)] <= F[i] for all i; busy <= 1; go to S1.
  - F may change after edge N without effect.
- Edges N+1..N+3 (S1..S3): stage s replaces work with butterfly outputs.
  - Span = 2^(s-1); pairs are (j, j+span) with j mod 2span < span.
  - Twiddle is W16^-k = conj(W16^k), with k = (j mod span)*(8/span).
- Edge N+4 (S4): stage 4 results go directly into f[0:15]; done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency is 4 cycles start-to-done. Earliest next accept is edge N+5, so throughput is 1 transform per 5 cycles.
- start is ignored while busy (no queueing).
- start held continuously restarts each time IDLE is reached.
- f holds the last result until the next done or reset.
- Butterfly arithmetic, per half-word with H = WIDTH/2:
  - Complex product P = W*B, computed as 2H-bit partial products.
  - P.re = (Wr*Br - Wi*Bi)[2H-2:H-1], with P.im formed the same way; this truncates.
  - Sum/difference A±P is computed at H+1 bits, then arithmetic shift right by 1 back to H bits. No overflow is possible, so there is no saturation.
  - The total 1/16 scaling is inherent.
- Twiddle +j (conj of W16^4) uses im = 2^(H-1)-1 (max positive), because +1.0 is unrepresentable.
- Reset asserted mid-transform: abort immediately; no done pulse; f reads zeros.
- Reset deasserted with start=1: accept at the first clock edge after release.

Decomposition:
- Package fft_pkg (shared with fft_16pt): localparams W16_0..W16_7 and their conjugates W16C_0..W16C_7 (WIDTH=36); state enum for IFFT states; function bitrev4.
- Sub-module ifft_butterfly_scaled #(WIDTH) (A, B, W -> (A+WB)/2, (A-WB)/2).
  - Purely combinational; 8 instances.
  - The existing butterfly_unit cannot be reused because it lacks the guard bit.

Test Plan:
- Impulse: F[0]={18'h10000,18'h0} (0.5), rest 0, start -> done exactly 4 cycles after accept; every f[n]={18'h01000,18'h0}, exact.
- Constant: all F[k]={18'h10000,0} -> f[0]={18'h10000,0}, f[1..15]=0 exactly; busy high 4 cycles.
- Direction check: F[1]={18'h10000,0} only -> f[4] within +/-4 LSB of {0,18'h01000} (positive imag); f[12] within +/-4 LSB of {0,-18'h01000}.
- Round trip: 100 random vectors with |re|,|im| <= 2^12, passed through fft_16pt then ifft_16pt -> output equals original within +/-16 LSB per component.
- Handshake: start pulsed during S2 is ignored (single done); F changed on the cycle after accept does not alter f; start asserted the cycle after done is accepted, next done follows 5 cycles after the previous one.
- Reset mid-op: assert reset in S3 -> busy=0, done=0, f all 0 before the next edge; no done pulse; next start produces a correct impulse result.
